comparator_stream_pipe: RTL and testbench
=========================================

Name: comparator_stream_pipe

Overview:
- Streaming magnitude comparator that consumes comparator_in operand pairs (a, b, signed-mode) over a valid/ready handshake.
- Produces registered gt/eq/lt result flags downstream over a second valid/ready handshake.
- Two-stage pipeline with full backpressure support and per-result saturating statistics counters.
- Sits directly downstream of the comparator_in agent's driven interface and feeds the comparator_out monitor/scoreboard path.

Parameters:
- WIDTH, 8, operand width in bits (min 1).
- CNT_W, 16, width of each statistics counter (min 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_signed  input  1  1 = compare as two's complement, 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_gt  output  1  A > B.
- out_eq  output  1  A == B.
- out_lt  output  1  A < B.
- stats_clr  input  1  synchronous clear of all counters.
- cnt_gt  output  CNT_W  count of accepted gt results.
- cnt_eq  output  CNT_W  count of accepted eq results.
- cnt_lt  output  CNT_W  count of accepted lt results.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid, s2_valid = 0; out_valid = 0.
  - out_gt, out_eq, out_lt = 0.
  - All counters = 0.
  - in_ready = 1 combinationally once s1/s2 are empty.
- Stage S1 captures {in_a, in_b, in_signed} on an input handshake (in_valid & in_ready).
- Stage S2 holds the registered results:
  - Signed mode: compare sign-extended operands.
  - Unsigned mode: compare zero-extended operands.
  - Exactly one of gt/eq/lt is 1 whenever out_valid = 1.
- Advance rules (standard ready chain):
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no in_valid -> in_ready path).
- Latency: input handshake at cycle N -> out_valid at cycle N+2 when out_ready is held high. Throughput is 1 pair/cycle.
- Backpressure:
  - While out_ready = 0 and both stages are full, in_ready = 0.
  - S1 and S2 contents and outputs hold stable; no data is dropped or duplicated.
  - out_valid, once asserted, stays high with stable flags until out_ready = 1.
- Bubbles: empty stages are filled without waiting for downstream. A single pair with out_ready = 0 sits in S2, and S1 can still accept one more.
- Counters:
  - On an output handshake (out_valid & out_ready), the counter matching the asserted flag increments by 1.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
- stats_clr:
  - Sets all counters to 0 on the next edge.
  - Clear and handshake in the same cycle: clear wins, counter = 0.
  - Pipeline data is unaffected.
- Reset mid-operation: in-flight pairs are discarded and out_valid drops immediately (async). After release, the first accepted pair again has 2-cycle latency.
- WIDTH = 1: signed mode treats 1 as -1 (1 < 0 signed).

Test Plan:
- Signed/unsigned, WIDTH=8, out_ready=1: a=8'h80, b=8'h01.
  - in_signed=1 -> lt=1 at cycle N+2.
  - in_signed=0 -> gt=1.
  - a=b=8'h5A -> eq=1.
- Back-to-back streaming: 100 random pairs with in_valid and out_ready constantly 1 -> 100 results in order, one per cycle, first at +2 cycles; cnt_gt+cnt_eq+cnt_lt = 100.
- Backpressure: out_ready=0 for 10 cycles while in_valid=1 -> exactly 2 pairs accepted, in_ready=0 thereafter, outputs stable. Then release -> both results delivered in order with no loss or duplication.
- Saturation with CNT_W=2: 5 accepted eq results -> cnt_eq sticks at 3; cnt_gt and cnt_lt stay 0.
- Clear collision: stats_clr=1 in the same cycle as a gt handshake with cnt_gt=7 -> cnt_gt=0 next cycle, and the next gt handshake gives 1.
- Async reset: assert rst_n=0 mid-cycle with both stages full -> out_valid=0 and counters=0 immediately. After release, no stale result appears, and a new pair a=3, b=9 (unsigned) -> lt=1 at +2 cycles.

Source files
------------

// File: rtl/comparator_stream_pipe.sv
// comparator_stream_pipe: two-stage valid/ready magnitude comparator with saturating result counters
module comparator_stream_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_lt,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
);
  logic             s1_valid, s1_signed, s2_valid, s1_adv, s2_adv, out_fire;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic signed [WIDTH:0] ext_a, ext_b;
  assign s2_adv    = !s2_valid | out_ready;
  assign s1_adv    = !s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid & out_ready;
  // one extra bit makes a single signed compare serve both modes
  assign ext_a = {s1_signed & s1_a[WIDTH-1], s1_a};
  assign ext_b = {s1_signed & s1_b[WIDTH-1], s1_b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_signed <= in_signed;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_gt   <= 1'b0;
      out_eq   <= 1'b0;
      out_lt   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      out_gt   <= s1_valid & (ext_a > ext_b);
      out_eq   <= s1_valid & (ext_a == ext_b);
      out_lt   <= s1_valid & (ext_a < ext_b);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (stats_clr) begin
      cnt_gt <= '0;
      cnt_eq <= '0;
      cnt_lt <= '0;
    end else if (out_fire) begin
      if (out_gt && cnt_gt != '1) cnt_gt <= cnt_gt + 1'b1;
      if (out_eq && cnt_eq != '1) cnt_eq <= cnt_eq + 1'b1;
      if (out_lt && cnt_lt != '1) cnt_lt <= cnt_lt + 1'b1;
    end
endmodule

// File: tb/tb_comparator_stream_pipe.sv
// tb_comparator_stream_pipe: directed checks of the streaming comparator, plus a 2-bit-counter instance
module tb_comparator_stream_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_signed = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b1, out_gt, out_eq, out_lt, stats_clr = 1'b0;
  logic [15:0] cnt_gt, cnt_eq, cnt_lt;
  logic        s_in_valid = 1'b0, s_in_ready, s_signed = 1'b0, s_out_valid, s_out_ready = 1'b1;
  logic        s_gt, s_eq, s_lt, s_clr = 1'b0;
  logic [7:0]  s_a = '0, s_b = '0;
  logic [1:0]  s_cnt_gt, s_cnt_eq, s_cnt_lt;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  comparator_stream_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(out_valid), .out_ready(out_ready), .out_gt(out_gt),
    .out_eq(out_eq), .out_lt(out_lt), .stats_clr(stats_clr), .cnt_gt(cnt_gt), .cnt_eq(cnt_eq),
    .cnt_lt(cnt_lt)
  );

  comparator_stream_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_a), .in_b(s_b),
    .in_signed(s_signed), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_gt(s_gt),
    .out_eq(s_eq), .out_lt(s_lt), .stats_clr(s_clr), .cnt_gt(s_cnt_gt), .cnt_eq(s_cnt_eq),
    .cnt_lt(s_cnt_lt)
  );

  function automatic logic [2:0] exp_of(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ia, ib;
    ia = (s && a[7]) ? int'(a) - 256 : int'(a);
    ib = (s && b[7]) ? int'(b) - 256 : int'(b);
    return {ia > ib, ia == ib, ia < ib};
  endfunction

  task automatic test_reset;
    #3;
    n_vec++;
    if ({out_valid, out_gt, out_eq, out_lt, in_ready} !== 5'b00001) begin
      n_err++; $display("FAIL reset_out got %b want 00001", {out_valid, out_gt, out_eq, out_lt, in_ready});
    end
    n_vec++;
    if ({cnt_gt, cnt_eq, cnt_lt} !== 48'd0) begin
      n_err++; $display("FAIL reset_cnt got %h want 0", {cnt_gt, cnt_eq, cnt_lt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sign_modes;
    logic [3:0] want [3];
    want[0] = 4'b1001; want[1] = 4'b1100; want[2] = 4'b1010;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h80; in_b = 8'h01; in_signed = 1'b1;
    @(negedge clk);
    in_signed = 1'b0;
    @(negedge clk);
    in_a = 8'h5A; in_b = 8'h5A; in_signed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({out_valid, out_gt, out_eq, out_lt} !== want[i]) begin
        n_err++; $display("FAIL sign_mode[%0d] got %b want %b", i, {out_valid, out_gt, out_eq, out_lt}, want[i]);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL sign_mode_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_q [$];
    logic [2:0] e;
    logic [7:0] a, b;
    logic       s;
    int         ng = 0, ne = 0, nl = 0;
    @(negedge clk);
    stats_clr = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    stats_clr = 1'b0;
    for (int i = 0; i < 102; i++) begin
      if (i < 2) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL b2b_lead[%0d] got %b want 0", i, out_valid);
        end
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if ({out_valid, out_gt, out_eq, out_lt} !== {1'b1, e}) begin
          n_err++; $display("FAIL b2b[%0d] got %b want %b", i - 2, {out_valid, out_gt, out_eq, out_lt}, {1'b1, e});
        end
      end
      if (i < 100) begin
        a = 8'($urandom);
        b = ($urandom_range(3) == 0) ? a : 8'($urandom);
        s = 1'($urandom);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
        e = exp_of(a, b, s);
        exp_q.push_back(e);
        ng += int'(e[2]); ne += int'(e[1]); nl += int'(e[0]);
      end else in_valid = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if ({cnt_gt, cnt_eq, cnt_lt} !== {16'(ng), 16'(ne), 16'(nl)}) begin
      n_err++; $display("FAIL b2b_cnt got %0d/%0d/%0d want %0d/%0d/%0d", cnt_gt, cnt_eq, cnt_lt, ng, ne, nl);
    end
    n_vec++;
    if (int'(cnt_gt) + int'(cnt_eq) + int'(cnt_lt) != 100) begin
      n_err++; $display("FAIL b2b_sum got %0d want 100", int'(cnt_gt) + int'(cnt_eq) + int'(cnt_lt));
    end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    @(negedge clk);
    stats_clr = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    stats_clr = 1'b0;
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1; in_signed = 1'b0;
      in_a = (j == 0) ? 8'd10 : (j == 1) ? 8'd30 : 8'(j);
      in_b = (j < 2) ? 8'd20 : 8'(j);
      n_vec++;
      if (in_ready !== (j < 2)) begin
        n_err++; $display("FAIL bp_in_ready[%0d] got %b want %b", j, in_ready, j < 2);
      end
      if (in_ready === 1'b1) acc++;
      if (j >= 2) begin
        n_vec++;
        if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1001) begin
          n_err++; $display("FAIL bp_hold[%0d] got %b want 1001", j, {out_valid, out_gt, out_eq, out_lt});
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++;
    if (acc != 2) begin
      n_err++; $display("FAIL bp_accepted got %0d want 2", acc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1100) begin
      n_err++; $display("FAIL bp_second got %b want 1100", {out_valid, out_gt, out_eq, out_lt});
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain got %b want 0", out_valid);
    end
    @(negedge clk);
    n_vec++;
    if ({cnt_gt, cnt_eq, cnt_lt} !== {16'd1, 16'd0, 16'd1}) begin
      n_err++; $display("FAIL bp_cnt got %0d/%0d/%0d want 1/0/1", cnt_gt, cnt_eq, cnt_lt);
    end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_a = 8'(8'h40 + i); s_b = 8'(8'h40 + i); s_signed = 1'(i);
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({s_cnt_gt, s_cnt_eq, s_cnt_lt} !== 6'b00_11_00) begin
      n_err++; $display("FAIL sat_cnt got %0d/%0d/%0d want 0/3/0", s_cnt_gt, s_cnt_eq, s_cnt_lt);
    end
  endtask

  task automatic test_clear_collision;
    @(negedge clk);
    stats_clr = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    stats_clr = 1'b0;
    in_a = 8'd9; in_b = 8'd2; in_signed = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (cnt_gt !== 16'd7) begin
      n_err++; $display("FAIL clr_pre got %0d want 7", cnt_gt);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1100) begin
      n_err++; $display("FAIL clr_parked got %b want 1100", {out_valid, out_gt, out_eq, out_lt});
    end
    stats_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    n_vec++;
    if ({out_valid, cnt_gt} !== 17'd0) begin
      n_err++; $display("FAIL clr_collide got valid=%b cnt=%0d want valid=0 cnt=0", out_valid, cnt_gt);
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cnt_gt !== 16'd1) begin
      n_err++; $display("FAIL clr_after got %0d want 1", cnt_gt);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2; in_signed = 1'b0;
    @(negedge clk);
    in_a = 8'd5; in_b = 8'd4;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_err++; $display("FAIL rst_full got %b want 10", {out_valid, in_ready});
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_gt, out_eq, out_lt, in_ready} !== 5'b00001) begin
      n_err++; $display("FAIL rst_async_out got %b want 00001", {out_valid, out_gt, out_eq, out_lt, in_ready});
    end
    n_vec++;
    if ({cnt_gt, cnt_eq, cnt_lt} !== 48'd0) begin
      n_err++; $display("FAIL rst_async_cnt got %h want 0", {cnt_gt, cnt_eq, cnt_lt});
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_stale got %b want 0", out_valid);
    end
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd9; in_signed = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_early got %b want 0", out_valid);
    end
    @(negedge clk);
    n_vec++;
    if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1001) begin
      n_err++; $display("FAIL rst_new got %b want 1001", {out_valid, out_gt, out_eq, out_lt});
    end
  endtask

  initial begin
    test_reset;
    test_sign_modes;
    test_back_to_back;
    test_backpressure;
    test_saturation;
    test_clear_collision;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
